rr_select2: RTL

Two-channel round-robin selector that sits directly upstream of the 2:1 multiplexer stage. It arbitrates between two valid/ready input channels (`in0`, `in1`) and registers the winning data on `f`. It drives the select line `s` for downstream muxing and keeps per-channel accepted-transfer counters. It is fair under contention: with both channels continuously valid, grants alternate every accepted transfer.

---
 rtl/rr_select2.sv | 73 +++++++
 1 files changed

// File: rtl/rr_select2.sv
// Two-channel round-robin selector with a registered output word, a mux select
// and per-channel accepted-transfer counters.
//
// state | meaning
// EMPTY | f_valid=0, output register holds no unconsumed word
// FULL  | f_valid=1, f/s hold a word waiting for f_ready
module rr_select2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  input  logic             f_ready,
  output logic             s,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic ptr;
  logic sel;
  logic load_en;
  logic take;

  always_comb begin
    sel = in1_valid;
    if (in0_valid && in1_valid) sel = ptr;
  end

  assign load_en = (f_valid == EMPTY) || f_ready;

  // Readies are held low during reset so no handshake is seen on that edge.
  assign in0_ready = !rst && load_en && !sel && in0_valid;
  assign in1_ready = !rst && load_en &&  sel && in1_valid;
  assign take      = in0_ready || in1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f       <= '0;
      s       <= 1'b0;
      f_valid <= EMPTY;
      ptr     <= 1'b0;
    end else if (take) begin
      f       <= sel ? in1 : in0;
      s       <= sel;
      f_valid <= FULL;
      ptr     <= ~sel;
    end else if (f_ready) begin
      f_valid <= EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (in0_ready) cnt0 <= cnt0 + 1'b1;
      if (in1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule
